touch_reader: RTL

- SPI master for the resistive touch controller (XPT2046-compatible) on the LCD panel.
- Detects pen-down via the controller's PENIRQ_n line and reads 12-bit X and Y positions.
- Drives the touch-level signal that the backlight idle timer consumes.
- Reports coordinate samples to the fractal-view control logic.

---
 rtl/touch_reader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/touch_reader.sv
// XPT2046-style touch controller reader: debounced pen detect,
// periodic 48-clock X/Y conversion frames over SPI mode 0.
module touch_reader #(
  parameter int CLKS_PER_HALF_SCLK = 8,
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int SAMPLE_INTERVAL    = 65536
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Penirq_L,
  input  logic        i_Miso,
  output logic        o_Sclk,
  output logic        o_Mosi,
  output logic        o_Cs_L,
  output logic        o_Touch,
  output logic        o_Sample_Valid,
  output logic [11:0] o_X,
  output logic [11:0] o_Y
);

  localparam int HW = $clog2(CLKS_PER_HALF_SCLK);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(SAMPLE_INTERVAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(CLKS_PER_HALF_SCLK - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IV_LAST  = IW'(SAMPLE_INTERVAL - 1);
  localparam logic [IW-1:0] MASK_CYC = IW'(2 * CLKS_PER_HALF_SCLK);

  // Whole-frame DIN pattern, edge 1 in bit 47
  localparam logic [47:0] FRAME_CMD =
    {8'hD0, 16'h0000, 8'h90, 16'h0000};

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    REPORT,
    INTERVAL,
    RELEASE_DB
  } state_t;

  state_t        state_q;
  logic          meta_q;
  logic          sync_q;
  logic [DW-1:0] db_cnt_q;
  logic [HW-1:0] hcnt_q;
  logic [5:0]    bit_q;
  logic [IW-1:0] int_cnt_q;
  logic [47:0]   cmd_q;
  logic [11:0]   x_sr_q;
  logic [11:0]   y_sr_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cs_q;
  logic          touch_q;
  logic          valid_q;
  logic [11:0]   x_q;
  logic [11:0]   y_q;

  logic          pen_down;
  logic          masked;
  logic          in_x;
  logic          in_y;
  logic [IW-1:0] int_cnt_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_Penirq_L;
      sync_q <= meta_q;
    end
  end

  always_comb begin
    pen_down  = ~sync_q;
    masked    = int_cnt_q < MASK_CYC;
    in_x      = (bit_q >= 6'd9) && (bit_q <= 6'd20);
    in_y      = (bit_q >= 6'd33) && (bit_q <= 6'd44);
    int_cnt_d = int_cnt_q;
    if (int_cnt_q != IV_LAST) begin
      int_cnt_d = int_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      hcnt_q    <= '0;
      bit_q     <= '0;
      int_cnt_q <= '0;
      cmd_q     <= '0;
      x_sr_q    <= '0;
      y_sr_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      touch_q   <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pen_down) begin
            state_q  <= PRESS_DB;
            db_cnt_q <= '0;
          end
        end
        PRESS_DB: begin
          if (!pen_down) begin
            state_q <= IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            touch_q <= 1'b1;
            state_q <= CS_SETUP;
            cs_q    <= 1'b0;
            hcnt_q  <= '0;
            mosi_q  <= FRAME_CMD[47];
            cmd_q   <= {FRAME_CMD[46:0], 1'b0};
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        CS_SETUP: begin
          if (hcnt_q == H_LAST) begin
            state_q <= SHIFT;
            hcnt_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (hcnt_q != H_LAST) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            hcnt_q <= '0;
            if (!sclk_q) begin
              // Rising edge: DOUT is sampled before SCLK goes high
              sclk_q <= 1'b1;
              if (in_x) begin
                x_sr_q <= {x_sr_q[10:0], i_Miso};
              end
              if (in_y) begin
                y_sr_q <= {y_sr_q[10:0], i_Miso};
              end
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 6'd47) begin
                state_q <= CS_HOLD;
                mosi_q  <= 1'b0;
              end else begin
                bit_q  <= bit_q + 1'b1;
                mosi_q <= cmd_q[47];
                cmd_q  <= {cmd_q[46:0], 1'b0};
              end
            end
          end
        end
        CS_HOLD: begin
          if (hcnt_q == H_LAST) begin
            cs_q      <= 1'b1;
            state_q   <= REPORT;
            int_cnt_q <= '0;
            if ((x_sr_q != 12'd0) && (y_sr_q != 12'd0)) begin
              x_q     <= x_sr_q;
              y_q     <= y_sr_q;
              valid_q <= 1'b1;
            end
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        REPORT: begin
          state_q   <= INTERVAL;
          int_cnt_q <= int_cnt_d;
        end
        INTERVAL: begin
          int_cnt_q <= int_cnt_d;
          if (!masked && !pen_down) begin
            state_q  <= RELEASE_DB;
            db_cnt_q <= '0;
          end else if (pen_down && (int_cnt_q == IV_LAST)) begin
            state_q <= CS_SETUP;
            cs_q    <= 1'b0;
            hcnt_q  <= '0;
            mosi_q  <= FRAME_CMD[47];
            cmd_q   <= {FRAME_CMD[46:0], 1'b0};
          end
        end
        RELEASE_DB: begin
          // Interval keeps running so a bounce does not delay polling
          int_cnt_q <= int_cnt_d;
          if (pen_down) begin
            state_q  <= INTERVAL;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            touch_q  <= 1'b0;
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Sclk         = sclk_q;
  assign o_Mosi         = mosi_q;
  assign o_Cs_L         = cs_q;
  assign o_Touch        = touch_q;
  assign o_Sample_Valid = valid_q;
  assign o_X            = x_q;
  assign o_Y            = y_q;

endmodule
